// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter sharing one RSA core between two requesters.
// Define RSA_ARB_TIMEOUT_EN to add the WAIT-state timeout and FAULT recovery.
module rsa_core_arbiter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd400000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic [255:0] i_a0,
  input  logic [255:0] i_d0,
  input  logic [255:0] i_n0,
  input  logic [255:0] i_a1,
  input  logic [255:0] i_d1,
  input  logic [255:0] i_n1,
  output logic         o_gnt0,
  output logic         o_gnt1,
  output logic         o_done0,
  output logic         o_done1,
  output logic [255:0] o_result,
  output logic         o_err,
  output logic         o_busy,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_a_pow_d,
  input  logic         i_core_finished
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE, S_FAULT
  } state_e;

  state_e       state_q;
  logic         owner_q;
  logic         last_id_q;
  logic         gnt0_q, gnt1_q, done0_q, done1_q;
  logic         start_q, busy_q;
  logic [255:0] result_q, core_a_q, core_d_q, core_n_q;
  logic         winner_c;

  // A lone request wins outright; on a tie the requester not served last wins.
  assign winner_c = (i_req0 && i_req1) ? ~last_id_q : i_req1;

`ifdef RSA_ARB_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        err_q;
  assign o_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign o_err      = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_id_q <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      result_q  <= '0;
      core_a_q  <= '0;
      core_d_q  <= '0;
      core_n_q  <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_req0 || i_req1) begin
            owner_q  <= winner_c;
            core_a_q <= winner_c ? i_a1 : i_a0;
            core_d_q <= winner_c ? i_d1 : i_d0;
            core_n_q <= winner_c ? i_n1 : i_n0;
            gnt0_q   <= ~winner_c;
            gnt1_q   <= winner_c;
            busy_q   <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          start_q <= 1'b1;
          state_q <= S_START;
        end
        S_START: begin
`ifdef RSA_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_core_finished) begin
            result_q <= i_core_a_pow_d;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            state_q  <= S_DONE;
`ifdef RSA_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
          end else if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
            // Hung core: report an error to the owner, then drain the late result in FAULT.
            result_q  <= '0;
            err_q     <= 1'b1;
            done0_q   <= ~owner_q;
            done1_q   <= owner_q;
            last_id_q <= owner_q;
            state_q   <= S_FAULT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
`endif
          end
        end
        S_DONE: begin
          last_id_q <= owner_q;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
`ifdef RSA_ARB_TIMEOUT_EN
        S_FAULT: begin
          if (i_core_finished) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gnt0       = gnt0_q;
  assign o_gnt1       = gnt1_q;
  assign o_done0      = done0_q;
  assign o_done1      = done1_q;
  assign o_core_start = start_q;
  assign o_busy       = busy_q;
  assign o_result     = result_q;
  assign o_core_a     = core_a_q;
  assign o_core_d     = core_d_q;
  assign o_core_n     = core_n_q;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Self-checking bench for rsa_core_arbiter: timeline model plus directed scenarios.
// Timeout scenario runs only when RSA_ARB_TIMEOUT_EN is defined.
module tb_rsa_core_arbiter;

  localparam logic [31:0] TC = 32'd16;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_req0, i_req1;
  logic [255:0] i_a0, i_d0, i_n0, i_a1, i_d1, i_n1;
  logic         o_gnt0, o_gnt1, o_done0, o_done1;
  logic [255:0] o_result;
  logic         o_err, o_busy, o_core_start;
  logic [255:0] o_core_a, o_core_d, o_core_n;
  logic [255:0] i_core_a_pow_d;
  logic         i_core_finished;

  rsa_core_arbiter #(.TIMEOUT_CYCLES(TC)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0(i_req0), .i_req1(i_req1),
    .i_a0(i_a0), .i_d0(i_d0), .i_n0(i_n0),
    .i_a1(i_a1), .i_d1(i_d1), .i_n1(i_n1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_done0(o_done0), .o_done1(o_done1),
    .o_result(o_result), .o_err(o_err), .o_busy(o_busy),
    .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_d(o_core_d), .o_core_n(o_core_n),
    .i_core_a_pow_d(i_core_a_pow_d), .i_core_finished(i_core_finished)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] modexp(input logic [255:0] a, input logic [255:0] d,
                                         input logic [255:0] n);
    longint unsigned r = 1;
    longint unsigned b = a[63:0];
    longint unsigned m = n[63:0];
    for (int k = 0; k < int'(d[31:0]); k++) r = (r * b) % m;
    return 256'(r);
  endfunction

  // Timeline model: cycle c is the interval after the c-th edge since reset.
  int           cyc, g_m, idle_from_m;
  bit           job_m, fault_m, owner_m, last_m;
  bit           gnt0_m, gnt1_m, done0_m, done1_m, start_m, err_m;
  logic [255:0] res_m, ca_m, cd_m, cn_m;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cyc = 0; g_m = 0; idle_from_m = 0;
      job_m = 0; fault_m = 0; owner_m = 0; last_m = 1;
      gnt0_m = 0; gnt1_m = 0; done0_m = 0; done1_m = 0; start_m = 0; err_m = 0;
      res_m = '0; ca_m = '0; cd_m = '0; cn_m = '0;
    end else begin
      bit idle_prev;
      int e;
      e = cyc + 1;
      idle_prev = !job_m && !fault_m && (cyc >= idle_from_m);
      gnt0_m = 0; gnt1_m = 0; done0_m = 0; done1_m = 0; start_m = 0;
      if (fault_m) begin
        if (i_core_finished) begin fault_m = 0; idle_from_m = e; end
      end else if (job_m && cyc >= g_m + 2) begin
        if (i_core_finished) begin
          res_m = i_core_a_pow_d; err_m = 0;
          done0_m = !owner_m; done1_m = owner_m;
          job_m = 0; idle_from_m = e + 1; last_m = owner_m;
        end
`ifdef RSA_ARB_TIMEOUT_EN
        else if (cyc == g_m + 1 + int'(TC)) begin
          res_m = '0; err_m = 1;
          done0_m = !owner_m; done1_m = owner_m;
          job_m = 0; fault_m = 1; last_m = owner_m;
        end
`endif
      end
      if (job_m && e == g_m + 1) start_m = 1;
      if (idle_prev && (i_req0 || i_req1)) begin
        owner_m = (i_req0 && i_req1) ? !last_m : i_req1;
        job_m = 1; g_m = e;
        ca_m = owner_m ? i_a1 : i_a0;
        cd_m = owner_m ? i_d1 : i_d0;
        cn_m = owner_m ? i_n1 : i_n0;
        gnt0_m = !owner_m; gnt1_m = owner_m;
      end
      cyc = e;
    end
  end

  // Per-cycle comparison plus event log.
  int ngnt[2], ndone[2], gnt_cyc[2];
  always @(negedge i_clk) begin
    if (!i_rst) begin
      bit busy_m;
      busy_m = job_m || fault_m || (cyc < idle_from_m);
      chk("ctrl{g0,g1,d0,d1,st,busy,err}",
          {o_gnt0, o_gnt1, o_done0, o_done1, o_core_start, o_busy, o_err},
          {gnt0_m, gnt1_m, done0_m, done1_m, start_m, busy_m, err_m});
      chk("result", o_result, res_m);
      chk("core_a", o_core_a, ca_m);
      chk("core_d", o_core_d, cd_m);
      chk("core_n", o_core_n, cn_m);
      if (o_gnt0) begin ngnt[0]++; gnt_cyc[0] = cyc; end
      if (o_gnt1) begin ngnt[1]++; gnt_cyc[1] = cyc; end
      if (o_done0) ndone[0]++;
      if (o_done1) ndone[1]++;
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic wait_gnt(output int who, input int budget);
    who = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_gnt0) begin who = 0; return; end
      if (o_gnt1) begin who = 1; return; end
    end
    checks++; failures++;
    $display("FAIL wait_gnt: no grant within %0d cycles", budget);
  endtask

  task automatic wait_done(input int who, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((who == 0) ? o_done0 : o_done1) return;
    end
    checks++; failures++;
    $display("FAIL wait_done%0d: no done within %0d cycles", who, budget);
  endtask

  // Core presents its answer for one cycle; the next cycle is already visible on return.
  task automatic reply(input logic [255:0] v);
    i_core_finished = 1'b1;
    i_core_a_pow_d  = v;
    tick();
    i_core_finished = 1'b0;
    i_core_a_pow_d  = 256'hffff_ffff;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
  endtask

  int w, t_req, d_cyc, n_before;
  int order[4];
  int exp_order[4] = '{0, 1, 0, 1};

  initial begin
    i_rst = 1'b1;
    i_req0 = 0; i_req1 = 0;
    i_a0 = '0; i_d0 = '0; i_n0 = '0; i_a1 = '0; i_d1 = '0; i_n1 = '0;
    i_core_a_pow_d = '0; i_core_finished = 0;
    tick(); tick();
    chk("rst_ctrl", {o_gnt0, o_gnt1, o_done0, o_done1, o_core_start, o_busy, o_err}, '0);
    chk("rst_result", o_result, '0);
    chk("rst_core_a", o_core_a, '0);
    i_rst = 1'b0;

    // Single job: 2^3 mod 11 = 8.
    i_a0 = 256'd2; i_d0 = 256'd3; i_n0 = 256'd11; i_req0 = 1;
    t_req = cyc;
    wait_gnt(w, 10);
    chk("t1_owner", w, 0);
    chk("t1_gnt_latency", gnt_cyc[0] - t_req, 1);
    i_req0 = 0; i_a0 = '1;
    tick();
    chk("t1_start", o_core_start, 1);
    tick(); tick(); tick();
    reply(modexp(256'd2, 256'd3, 256'd11));
    chk("t1_done0", o_done0, 1);
    chk("t1_result", o_result, 256'd8);
    chk("t1_err", o_err, 0);
    tick(); tick();

    // Tie from reset, both held: grants alternate 0,1,0,1.
    do_reset();
    i_a0 = 256'd5; i_d0 = 256'd3; i_n0 = 256'd13;
    i_a1 = 256'd3; i_d1 = 256'd4; i_n1 = 256'd7;
    i_req0 = 1; i_req1 = 1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(w, 10);
      order[k] = w;
      tick(); tick();
      reply(modexp(ca_m, cd_m, cn_m));
      if (k == 3) begin i_req0 = 0; i_req1 = 0; end
      chk("t2_done", (w == 1) ? o_done1 : o_done0, 1);
    end
    for (int k = 0; k < 4; k++) chk("t2_order", order[k], exp_order[k]);
    chk("t2_last_result", o_result, 256'd4);
    tick(); tick();

    // Request 1 arrives during WAIT of job 0.
    i_a0 = 256'd7; i_d0 = 256'd2; i_n0 = 256'd10; i_req0 = 1;
    wait_gnt(w, 10);
    i_req0 = 0;
    tick(); tick();
    i_a1 = 256'd3; i_d1 = 256'd3; i_n1 = 256'd5; i_req1 = 1;
    n_before = ngnt[1];
    tick(); tick(); tick();
    reply(modexp(ca_m, cd_m, cn_m));
    chk("t3_done0", o_done0, 1);
    chk("t3_result0", o_result, 256'd9);
    chk("t3_no_early_gnt1", ngnt[1] - n_before, 0);
    d_cyc = cyc;
    wait_gnt(w, 10);
    chk("t3_owner", w, 1);
    chk("t3_gnt1_gap", cyc - d_cyc, 2);
    i_req1 = 0;
    tick(); tick();
    reply(modexp(ca_m, cd_m, cn_m));
    chk("t3_done1", o_done1, 1);
    chk("t3_result1", o_result, 256'd2);
    tick(); tick();

    // Spurious finished in IDLE, LOAD and START is ignored.
    n_before = ndone[0] + ndone[1];
    i_core_finished = 1; i_core_a_pow_d = 256'hdead;
    tick(); tick();
    i_core_finished = 0;
    chk("t4_idle_result", o_result, 256'd2);
    i_a0 = 256'd2; i_d0 = 256'd5; i_n0 = 256'd13; i_req0 = 1;
    wait_gnt(w, 10);
    i_req0 = 0;
    i_core_finished = 1; i_core_a_pow_d = 256'hbeef;
    tick(); tick();
    i_core_finished = 0;
    tick(); tick(); tick();
    chk("t4_no_done", (ndone[0] + ndone[1]) - n_before, 0);
    chk("t4_hold_result", o_result, 256'd2);
    reply(modexp(ca_m, cd_m, cn_m));
    chk("t4_done0", o_done0, 1);
    chk("t4_result", o_result, 256'd6);
    tick(); tick();

    // Asynchronous reset mid-WAIT abandons the job.
    i_a0 = 256'd4; i_d0 = 256'd2; i_n0 = 256'd9; i_req0 = 1;
    wait_gnt(w, 10);
    i_req0 = 0;
    tick(); tick(); tick();
    n_before = ndone[0] + ndone[1];
    #2 i_rst = 1'b1;
    #1;
    chk("t5_async_ctrl", {o_gnt0, o_gnt1, o_done0, o_done1, o_core_start, o_busy, o_err}, '0);
    chk("t5_async_result", o_result, '0);
    chk("t5_async_core_a", o_core_a, '0);
    tick();
    i_rst = 1'b0;
    tick(); tick(); tick();
    chk("t5_no_done", (ndone[0] + ndone[1]) - n_before, 0);
    i_req0 = 1;
    wait_gnt(w, 10);
    i_req0 = 0;
    tick(); tick();
    reply(modexp(ca_m, cd_m, cn_m));
    chk("t5_done0", o_done0, 1);
    chk("t5_result", o_result, 256'd7);
    tick(); tick();

`ifdef RSA_ARB_TIMEOUT_EN
    // Hung core: error done after 16 WAIT cycles, requester 1 held off until the late finish.
    i_a0 = 256'd2; i_d0 = 256'd3; i_n0 = 256'd11; i_req0 = 1;
    wait_gnt(w, 10);
    d_cyc = cyc;
    i_req0 = 0;
    i_a1 = 256'd3; i_d1 = 256'd3; i_n1 = 256'd5; i_req1 = 1;
    wait_done(0, 40);
    chk("t6_timeout_latency", cyc - d_cyc, 18);
    chk("t6_err", o_err, 1);
    chk("t6_result", o_result, '0);
    n_before = ngnt[1];
    repeat (5) tick();
    chk("t6_no_gnt1", ngnt[1] - n_before, 0);
    chk("t6_busy", o_busy, 1);
    reply(256'hbad);
    wait_gnt(w, 4);
    chk("t6_owner", w, 1);
    i_req1 = 0;
    tick(); tick();
    reply(modexp(ca_m, cd_m, cn_m));
    chk("t6_done1", o_done1, 1);
    chk("t6_err_clear", o_err, 0);
    chk("t6_result1", o_result, 256'd2);
    tick(); tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
